// File: rtl/spi_frame_tx_if.sv
// Result-vector stream from the filter output stage into the SPI frame transmitter.
interface spi_frame_tx_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/spi_frame_tx.sv
// SPI mode-0 slave transmitter: FIFO of NUM_CH x DATA_W vectors, one vector per
// chip-select frame behind an 8-bit {valid, overflow, seq} header, MSB first.
module spi_frame_tx #(
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_frame_tx_if.slave                 in_if,
    input  logic                          rpi_sck,
    input  logic                          rpi_cs,
    output logic                          rpi_miso,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int PW         = NUM_CH * DATA_W;
    localparam int FRAME_BITS = 8 + PW;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int LW         = AW + 1;
    localparam int CW         = $clog2(FRAME_BITS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
    logic                   sck_prev_q, cs_prev_q;
    logic [1:0]             state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   hdr_ovf_q, hdr_ovf_d;
    logic [5:0]             seq_q, seq_d;
    logic                   overflow_q, overflow_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          count_q, count_d;
    logic [PW-1:0]          mem_q [FIFO_DEPTH];

    logic sck_fall, cs_fall, cs_rise;
    logic wr_en, drop, commit, pop, ovf_clr, fifo_nonempty;

    assign sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], rpi_sck};
    assign cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], rpi_cs};
    assign sck_fall   = sck_prev_q & ~sck_sync_q[SYNC_STAGES-1];
    assign cs_fall    = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
    assign cs_rise    = ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];

    assign in_if.in_ready = (count_q != FULL_LVL);
    assign wr_en          = in_if.in_valid & in_if.in_ready;
    assign drop           = in_if.in_valid & ~in_if.in_ready;
    assign fifo_nonempty  = (count_q != '0);

    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign rpi_miso   = (state_q == SHIFT) ? shift_q[FRAME_BITS-1] : 1'b1;

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        frame_valid_d = frame_valid_q;
        hdr_ovf_d     = hdr_ovf_q;
        commit        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    // Head is peeked only; it is popped when the frame completes.
                    shift_d       = fifo_nonempty
                                    ? {1'b1, overflow_q, seq_q, mem_q[rd_ptr_q]}
                                    : {1'b0, overflow_q, seq_q, {PW{1'b1}}};
                    cnt_d         = '0;
                    frame_valid_d = fifo_nonempty;
                    hdr_ovf_d     = overflow_q;
                    state_d       = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sck_fall) begin
                    if (cnt_q == LAST_BIT) begin
                        state_d = DONE;
                        commit  = 1'b1;
                        shift_d = '1;
                    end else begin
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b1};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pop        = commit & frame_valid_q;
        ovf_clr    = commit & (frame_valid_q | hdr_ovf_q);
        overflow_d = drop | (overflow_q & ~ovf_clr);
        seq_d      = pop ? seq_q + 6'd1 : seq_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q    <= '1;
            cs_sync_q     <= '1;
            sck_prev_q    <= 1'b1;
            cs_prev_q     <= 1'b1;
            state_q       <= IDLE;
            shift_q       <= '1;
            cnt_q         <= '0;
            frame_valid_q <= 1'b0;
            hdr_ovf_q     <= 1'b0;
            seq_q         <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            cs_sync_q     <= cs_sync_d;
            sck_prev_q    <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q     <= cs_sync_q[SYNC_STAGES-1];
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            frame_valid_q <= frame_valid_d;
            hdr_ovf_q     <= hdr_ovf_d;
            seq_q         <= seq_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the reset pointers/count make stale
    // entries unreachable, and leaving it out keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_if.in_data;
    end
endmodule
